// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared widths, response codes and FSM/owner encodings for
//                the fetch/lsu AXI-lite merge arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam int C_ADDR_W = 32;
    localparam int C_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_AWW = 3'd3,
        WR_B   = 3'd4
    } state_e;

    typedef enum logic {
        FETCH = 1'b0,
        LSU   = 1'b1
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-request round-robin picker. Bit 0 is fetch, bit 1 is
//                lsu. On a tie the port that was not granted last wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,   // 1: lsu was granted last, 0: fetch was
    output logic [1:0] o_gnt
);

    // One-hot grant; the tie case favours the port that waited.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_arbiter
//  Description : Merges the fetch (read-only) and lsu (read/write) AXI-lite
//                initiators onto one downstream port. Exactly one transaction
//                is in flight; reads are round-robin, a pending lsu write
//                always wins. Payload is combinational pass-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_arbiter
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    // fetch responder
    input  logic [ADDR_W-1:0]     f_araddr,
    input  logic                  f_arvalid,
    output logic                  f_arready,
    output logic [DATA_W-1:0]     f_rdata,
    output logic [1:0]            f_rresp,
    output logic                  f_rvalid,
    input  logic                  f_rready,
    // lsu responder
    input  logic [ADDR_W-1:0]     l_araddr,
    input  logic                  l_arvalid,
    output logic                  l_arready,
    output logic [DATA_W-1:0]     l_rdata,
    output logic [1:0]            l_rresp,
    output logic                  l_rvalid,
    input  logic                  l_rready,
    input  logic [ADDR_W-1:0]     l_awaddr,
    input  logic                  l_awvalid,
    output logic                  l_awready,
    input  logic [DATA_W-1:0]     l_wdata,
    input  logic [DATA_W/8-1:0]   l_wstrb,
    input  logic                  l_wvalid,
    output logic                  l_wready,
    output logic [1:0]            l_bresp,
    output logic                  l_bvalid,
    input  logic                  l_bready,
    // downstream initiator
    output logic [ADDR_W-1:0]     m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    state_e     r_state;
    state_e     w_state_nxt;
    owner_e     r_own;
    owner_e     w_own_nxt;
    owner_e     r_rr_last;
    owner_e     w_rr_last_nxt;
    logic       r_aw_done;
    logic       w_aw_done_nxt;
    logic       r_w_done;
    logic       w_w_done_nxt;

    logic [1:0] w_gnt;
    logic       w_own_lsu;
    logic       w_ar_hs;
    logic       w_r_hs;
    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_b_hs;

    assign w_own_lsu = (r_own == LSU);

    assign w_ar_hs = m_arvalid & m_arready;
    assign w_r_hs  = m_rvalid  & m_rready;
    assign w_aw_hs = m_awvalid & m_awready;
    assign w_w_hs  = m_wvalid  & m_wready;
    assign w_b_hs  = m_bvalid  & m_bready;

    rr_arb2 u_rr_arb2 (
        .i_req  ({l_arvalid, f_arvalid}),
        .i_last (r_rr_last == LSU),
        .o_gnt  (w_gnt)
    );

    // Payload paths: no registers, only the owner select on the AR address.
    assign m_araddr = w_own_lsu ? l_araddr : f_araddr;
    assign m_awaddr = l_awaddr;
    assign m_wdata  = l_wdata;
    assign m_wstrb  = l_wstrb;
    assign f_rdata  = m_rdata;
    assign f_rresp  = m_rresp;
    assign l_rdata  = m_rdata;
    assign l_rresp  = m_rresp;
    assign l_bresp  = m_bresp;

    // Valid/ready routing: only the owner sees the downstream channel, and
    // a write channel that already completed its beat is closed off.
    always_comb begin
        m_arvalid = 1'b0;
        f_arready = 1'b0;
        l_arready = 1'b0;
        m_rready  = 1'b0;
        f_rvalid  = 1'b0;
        l_rvalid  = 1'b0;
        m_awvalid = 1'b0;
        l_awready = 1'b0;
        m_wvalid  = 1'b0;
        l_wready  = 1'b0;
        m_bready  = 1'b0;
        l_bvalid  = 1'b0;
        case (r_state)
            RD_AR: begin
                m_arvalid = w_own_lsu ? l_arvalid : f_arvalid;
                f_arready = ~w_own_lsu & m_arready;
                l_arready =  w_own_lsu & m_arready;
            end
            RD_R: begin
                m_rready  = w_own_lsu ? l_rready : f_rready;
                f_rvalid  = ~w_own_lsu & m_rvalid;
                l_rvalid  =  w_own_lsu & m_rvalid;
            end
            WR_AWW: begin
                m_awvalid = ~r_aw_done & l_awvalid;
                l_awready = ~r_aw_done & m_awready;
                m_wvalid  = ~r_w_done  & l_wvalid;
                l_wready  = ~r_w_done  & m_wready;
            end
            WR_B: begin
                m_bready  = l_bready;
                l_bvalid  = m_bvalid;
            end
            default: ;
        endcase
    end

    // Next-state: grant in IDLE, advance on each channel handshake.
    always_comb begin
        w_state_nxt   = r_state;
        w_own_nxt     = r_own;
        w_rr_last_nxt = r_rr_last;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            IDLE: begin
                if (l_awvalid) begin
                    w_own_nxt   = LSU;
                    w_state_nxt = WR_AWW;
                end else if (|w_gnt) begin
                    w_own_nxt   = w_gnt[1] ? LSU : FETCH;
                    w_state_nxt = RD_AR;
                end
            end
            RD_AR: begin
                if (w_ar_hs) begin
                    w_state_nxt   = RD_R;
                    w_rr_last_nxt = r_own;
                end
            end
            RD_R: begin
                if (w_r_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            WR_AWW: begin
                if (w_aw_hs) begin
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_w_done_nxt = 1'b1;
                end
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_nxt = WR_B;
                end
            end
            WR_B: begin
                if (w_b_hs) begin
                    w_state_nxt   = IDLE;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_rr_last_nxt = LSU;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State registers; reset makes fetch win the first read tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_own     <= FETCH;
            r_rr_last <= LSU;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_own     <= w_own_nxt;
            r_rr_last <= w_rr_last_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_arbiter
//  Description : Directed bench for axi_lite_arbiter with a small downstream
//                memory responder and upstream valid-drop helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_lite_arbiter;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] f_araddr = '0, l_araddr = '0, l_awaddr = '0, l_wdata = '0;
    logic        f_arvalid = 1'b0, l_arvalid = 1'b0, l_awvalid = 1'b0, l_wvalid = 1'b0;
    logic [3:0]  l_wstrb = '0;
    logic        f_rready = 1'b1, l_rready = 1'b1, l_bready = 1'b1;
    logic        f_arready, f_rvalid, l_arready, l_rvalid, l_awready, l_wready, l_bvalid;
    logic [31:0] f_rdata, l_rdata;
    logic [1:0]  f_rresp, l_rresp, l_bresp;
    logic [31:0] m_araddr, m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic        m_arready = 1'b0, m_rvalid = 1'b0, m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0, m_bresp = '0;

    always #5 clk = ~clk;

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .f_araddr(f_araddr), .f_arvalid(f_arvalid), .f_arready(f_arready),
        .f_rdata(f_rdata), .f_rresp(f_rresp), .f_rvalid(f_rvalid), .f_rready(f_rready),
        .l_araddr(l_araddr), .l_arvalid(l_arvalid), .l_arready(l_arready),
        .l_rdata(l_rdata), .l_rresp(l_rresp), .l_rvalid(l_rvalid), .l_rready(l_rready),
        .l_awaddr(l_awaddr), .l_awvalid(l_awvalid), .l_awready(l_awready),
        .l_wdata(l_wdata), .l_wstrb(l_wstrb), .l_wvalid(l_wvalid), .l_wready(l_wready),
        .l_bresp(l_bresp), .l_bvalid(l_bvalid), .l_bready(l_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    // All handshake-related outputs; must be zero in IDLE / reset.
    logic [11:0] w_ctl;
    assign w_ctl = {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, f_arready,
                    f_rvalid, l_arready, l_rvalid, l_awready, l_wready, l_bvalid};

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- responder / monitor state ----------------
    int          cyc = 0;
    int          n_m_ar = 0, n_m_r = 0, n_m_aw = 0, n_m_w = 0, n_f_r = 0, n_l_r = 0, n_l_b = 0;
    int          ar_stall_left = 0, ar_stall_seen = 0, dual_rvalid = 0;
    int          f_req_cyc = -1, m_arv_cyc = -1, b_hs_cyc = -1;
    bit          r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0, l_rvalid_seen = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = RESP_OKAY, cfg_bresp = RESP_OKAY;
    logic [31:0] cap_araddr = '0, cap_f_rdata = '0, cap_awaddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [1:0]  cap_f_rresp = '0, cap_bresp = '0;
    int          grant_q[$];

    // Downstream memory model plus upstream valid drop after handshake.
    initial begin
        bit drop_f_ar, drop_l_ar, drop_l_aw, drop_l_w, b_clr;
        forever begin
            @(negedge clk);
            cyc++;
            m_arready = (ar_stall_left == 0);
            m_rvalid  = r_pend;
            m_rdata   = cfg_rdata;
            m_rresp   = cfg_rresp;
            m_awready = 1'b1;
            m_wready  = 1'b1;
            m_bvalid  = b_pend;
            m_bresp   = cfg_bresp;
            #1;
            drop_f_ar = 0; drop_l_ar = 0; drop_l_aw = 0; drop_l_w = 0; b_clr = 0;
            if (!rst) begin
                if (f_arvalid && f_req_cyc < 0) f_req_cyc = cyc;
                if (m_arvalid && m_arv_cyc < 0) m_arv_cyc = cyc;
                if (l_rvalid) l_rvalid_seen = 1;
                if (f_rvalid && l_rvalid) dual_rvalid++;
                if (m_arvalid && !m_arready) begin
                    ar_stall_seen++;
                    if (ar_stall_left > 0) ar_stall_left--;
                end
                if (m_arvalid && m_arready) begin
                    n_m_ar++; cap_araddr = m_araddr; r_pend = 1; ar_stall_left = 0;
                end
                if (f_arvalid && f_arready) begin drop_f_ar = 1; grant_q.push_back(0); end
                if (l_arvalid && l_arready) begin drop_l_ar = 1; grant_q.push_back(1); end
                if (m_rvalid && m_rready) begin n_m_r++; r_pend = 0; end
                if (f_rvalid && f_rready) begin n_f_r++; cap_f_rdata = f_rdata; cap_f_rresp = f_rresp; end
                if (l_rvalid && l_rready) n_l_r++;
                if (m_awvalid && m_awready) begin n_m_aw++; cap_awaddr = m_awaddr; aw_got = 1; end
                if (m_wvalid && m_wready) begin n_m_w++; cap_wdata = m_wdata; cap_wstrb = m_wstrb; w_got = 1; end
                if (l_awvalid && l_awready) drop_l_aw = 1;
                if (l_wvalid && l_wready) drop_l_w = 1;
                if (m_bvalid && m_bready) b_clr = 1;
                if (l_bvalid && l_bready) begin n_l_b++; cap_bresp = l_bresp; b_hs_cyc = cyc; end
            end
            @(posedge clk);
            #1;
            if (drop_f_ar) f_arvalid = 1'b0;
            if (drop_l_ar) l_arvalid = 1'b0;
            if (drop_l_aw) l_awvalid = 1'b0;
            if (drop_l_w)  l_wvalid  = 1'b0;
            if (b_clr) b_pend = 0;
            if (aw_got && w_got && !b_pend) begin b_pend = 1; aw_got = 0; w_got = 0; end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (k < 200 && (f_arvalid || l_arvalid || l_awvalid || l_wvalid ||
                           r_pend || b_pend || aw_got || w_got)) begin
            step(1);
            k++;
        end
        check_val({tag, " timeout"}, 32'(k >= 200), 32'd0);
        step(1);
    endtask

    task automatic wait_rpend(input string tag);
        int k = 0;
        while (k < 100 && !r_pend) begin
            step(1);
            k++;
        end
        check_val({tag, " rpend timeout"}, 32'(k >= 100), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; ar_stall_left = 0;
        f_arvalid = 0; l_arvalid = 0; l_awvalid = 0; l_wvalid = 0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_f, b_l, b_aw, b_w, b_b, b_ar, b_mr, qn, win, k;

        do_reset();
        check_val("reset ctl outputs", 32'(w_ctl), 32'd0);

        // 1: lone fetch read
        cfg_rdata = 32'h0010_0093; cfg_rresp = RESP_OKAY;
        f_req_cyc = -1; m_arv_cyc = -1; l_rvalid_seen = 0; b_f = n_f_r;
        f_araddr = 32'h8000_0000; f_arvalid = 1'b1;
        wait_idle("t1");
        check_val("t1 araddr", cap_araddr, 32'h8000_0000);
        check_val("t1 f_rdata", cap_f_rdata, 32'h0010_0093);
        check_val("t1 f_rresp", 32'(cap_f_rresp), 32'd0);
        check_val("t1 f beats", 32'(n_f_r - b_f), 32'd1);
        check_val("t1 l_rvalid seen", 32'(l_rvalid_seen), 32'd0);
        check_val("t1 grant latency", 32'(m_arv_cyc - f_req_cyc), 32'd1);
        check_val("t1 idle ctl", 32'(w_ctl), 32'd0);

        // 2: eight read ties after reset, loser withdraws once the winner is granted
        do_reset();
        for (int t = 0; t < 8; t++) begin
            qn = grant_q.size();
            win = 7;
            f_araddr = 32'h8000_0010 + 32'(t); l_araddr = 32'h2000_0000 + 32'(t);
            cfg_rdata = 32'(t);
            f_arvalid = 1'b1; l_arvalid = 1'b1;
            k = 0;
            while (grant_q.size() == qn && k < 100) begin
                step(1);
                k++;
            end
            if (grant_q.size() > qn) begin
                win = grant_q[qn];
                if (win == 0) l_arvalid = 1'b0;
                else          f_arvalid = 1'b0;
            end else begin
                f_arvalid = 1'b0; l_arvalid = 1'b0;
            end
            wait_idle($sformatf("t2 tie%0d", t));
            check_val($sformatf("t2 tie%0d winner", t), 32'(win), 32'(t % 2));
        end

        // 3: lsu write, AW first, W three cycles later
        b_aw = n_m_aw; b_w = n_m_w; b_b = n_l_b; cfg_bresp = RESP_OKAY;
        l_awaddr = 32'h1000_0040; l_awvalid = 1'b1;
        step(3);
        l_wdata = 32'hDEAD_BEEF; l_wstrb = 4'b0011; l_wvalid = 1'b1;
        wait_idle("t3");
        check_val("t3 aw beats", 32'(n_m_aw - b_aw), 32'd1);
        check_val("t3 w beats", 32'(n_m_w - b_w), 32'd1);
        check_val("t3 awaddr", cap_awaddr, 32'h1000_0040);
        check_val("t3 wdata", cap_wdata, 32'hDEAD_BEEF);
        check_val("t3 wstrb", 32'(cap_wstrb), 32'h3);
        check_val("t3 b beats", 32'(n_l_b - b_b), 32'd1);
        check_val("t3 bresp", 32'(cap_bresp), 32'd0);

        // 4: write and fetch read requested together; write must finish first
        m_arv_cyc = -1; b_hs_cyc = -1; b_b = n_l_b; b_f = n_f_r;
        cfg_rdata = 32'h0000_0013;
        l_awaddr = 32'h1000_0044; l_wdata = 32'h0000_0055; l_wstrb = 4'hF;
        f_araddr = 32'h8000_0004;
        l_awvalid = 1'b1; l_wvalid = 1'b1; f_arvalid = 1'b1;
        wait_idle("t4");
        check_val("t4 b beats", 32'(n_l_b - b_b), 32'd1);
        check_val("t4 f beats", 32'(n_f_r - b_f), 32'd1);
        check_val("t4 write before read", 32'(b_hs_cyc >= 0 && m_arv_cyc > b_hs_cyc), 32'd1);
        check_val("t4 f_rdata", cap_f_rdata, 32'h0000_0013);

        // 5: AR stalled 5 cycles, then R stalled upstream, SLVERR forwarded
        ar_stall_left = 5; ar_stall_seen = 0;
        cfg_rdata = 32'hBAD0_0BAD; cfg_rresp = RESP_SLVERR;
        b_ar = n_m_ar; b_mr = n_m_r; b_f = n_f_r;
        f_rready = 1'b0;
        f_araddr = 32'h8000_0100; f_arvalid = 1'b1;
        wait_rpend("t5");
        step(4);
        check_val("t5 stalled f_rvalid", 32'(f_rvalid), 32'd1);
        check_val("t5 stalled m_rready", 32'(m_rready), 32'd0);
        check_val("t5 no beat while stalled", 32'(n_m_r - b_mr), 32'd0);
        f_rready = 1'b1;
        wait_idle("t5");
        check_val("t5 ar stall cycles", 32'(ar_stall_seen), 32'd5);
        check_val("t5 m ar beats", 32'(n_m_ar - b_ar), 32'd1);
        check_val("t5 m r beats", 32'(n_m_r - b_mr), 32'd1);
        check_val("t5 f beats", 32'(n_f_r - b_f), 32'd1);
        check_val("t5 rresp", 32'(cap_f_rresp), 32'h2);
        check_val("t5 rdata", cap_f_rdata, 32'hBAD0_0BAD);

        // 6: reset while in RD_R, then a normal read
        cfg_rresp = RESP_OKAY; cfg_rdata = 32'h5555_AAAA;
        f_rready = 1'b0; b_f = n_f_r;
        f_araddr = 32'h8000_0200; f_arvalid = 1'b1;
        wait_rpend("t6");
        step(2);
        check_val("t6 pre-reset f_rvalid", 32'(f_rvalid), 32'd1);
        rst = 1'b1; r_pend = 0;
        step(1);
        check_val("t6 reset ctl outputs", 32'(w_ctl), 32'd0);
        rst = 1'b0; f_rready = 1'b1;
        step(1);
        check_val("t6 abandoned beat", 32'(n_f_r - b_f), 32'd0);
        cfg_rdata = 32'h1234_5678;
        f_araddr = 32'h8000_0204; f_arvalid = 1'b1;
        wait_idle("t6");
        check_val("t6 next read beats", 32'(n_f_r - b_f), 32'd1);
        check_val("t6 next read data", cap_f_rdata, 32'h1234_5678);

        check_val("r beat conservation", 32'(n_m_r), 32'(n_f_r + n_l_r));
        check_val("dual rvalid cycles", 32'(dual_rvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
